// File: rtl/arbiter_pkg.sv
// Shared constants and types for the four-requester round-robin arbiter.
package arbiter_pkg;

    // Number of requesters and the width of an index into them.
    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;

    // One-hot (or all-zero) grant vector, bit N belongs to master N.
    typedef logic [NUM_REQ-1:0] grant_t;

    // Index of a requester; also used for the "last granted" pointer.
    typedef logic [PTR_W-1:0] ptr_t;

    // Pointer value after reset: the search starts at last+1, so 3 makes
    // master 0 the highest-priority requester.
    localparam ptr_t LAST_RESET = ptr_t'(NUM_REQ - 1);

    // True when at most one bit of the vector is set.
    function automatic logic is_onehot0(input grant_t v);
        return (v & (v - grant_t'(1))) == '0;
    endfunction

endpackage : arbiter_pkg

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: given the request vector and
// the index of the most recently granted master, returns the first
// asserted request found when searching from last+1 upward, wrapping.
module rr_pick
    import arbiter_pkg::*;
(
    input  grant_t req,
    input  ptr_t   last,
    output grant_t win,
    output ptr_t   win_idx,
    output logic   win_valid
);

    // Walk the rotating order once; the first hit wins and later hits are ignored.
    always_comb begin
        ptr_t cand;
        win       = '0;
        win_idx   = last;
        win_valid = 1'b0;
        cand      = last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr_t'(int'(last) + i);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
                win       = grant_t'(1) << cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// Grants change only on a rising clk edge; the active-low rst clears the
// grant immediately and restores master 0 as highest priority.
// Optional build macro ARB_LOCK_EN: the current holder keeps its grant
// for as long as its request stays asserted (lock until release). Without
// it, every edge re-arbitrates, so continuous requesters rotate per cycle.
module rr_arbiter
    import arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req3,
    input  logic req2,
    input  logic req1,
    input  logic req0,
    output logic gnt3,
    output logic gnt2,
    output logic gnt1,
    output logic gnt0
);

    grant_t req_vec;
    grant_t gnt_reg;
    grant_t gnt_next;
    ptr_t   last_reg;
    ptr_t   last_next;

    grant_t pick_win;
    ptr_t   pick_idx;
    logic   pick_valid;

    assign req_vec = {req3, req2, req1, req0};

    rr_pick u_pick (
        .req       (req_vec),
        .last      (last_reg),
        .win       (pick_win),
        .win_idx   (pick_idx),
        .win_valid (pick_valid)
    );

    // Next grant: hold a locked owner if enabled, else take the rotating winner.
    // With no requests the grant drops to zero and the pointer is kept.
    always_comb begin
        gnt_next  = '0;
        last_next = last_reg;
`ifdef ARB_LOCK_EN
        if ((gnt_reg & req_vec) != '0) begin
            gnt_next = gnt_reg;
        end else
`endif
        if (pick_valid) begin
            gnt_next  = pick_win;
            last_next = pick_idx;
        end
    end

    // Grant and pointer registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_reg  <= '0;
            last_reg <= LAST_RESET;
        end else begin
            gnt_reg  <= gnt_next;
            last_reg <= last_next;
        end
    end

    // Grants come straight from the register, never from req.
    assign gnt3 = gnt_reg[3];
    assign gnt2 = gnt_reg[2];
    assign gnt1 = gnt_reg[1];
    assign gnt0 = gnt_reg[0];

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter. A behavioural model holds the index
// of the last granted master and searches the rotating order with plain
// modulo arithmetic; each scenario task compares the DUT against it.
// Honours ARB_LOCK_EN in the model when the build defines it.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_v = 4'b0000;
    logic       gnt3, gnt2, gnt1, gnt0;
    logic [3:0] gnt_obs;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0] m_gnt;
    int         m_last;

    always #5 clk = ~clk;

    assign gnt_obs = {gnt3, gnt2, gnt1, gnt0};

    rr_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .req3 (req_v[3]),
        .req2 (req_v[2]),
        .req1 (req_v[1]),
        .req0 (req_v[0]),
        .gnt3 (gnt3),
        .gnt2 (gnt2),
        .gnt1 (gnt1),
        .gnt0 (gnt0)
    );

    function automatic void model_reset();
        m_gnt  = 4'b0000;
        m_last = 3;
    endfunction

    function automatic void model_edge(input logic [3:0] r);
        int idx;
`ifdef ARB_LOCK_EN
        if ((m_gnt & r) != 4'b0000) return;
`endif
        m_gnt = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (r[idx]) begin
                m_gnt  = 4'(1 << idx);
                m_last = idx;
                break;
            end
        end
    endfunction

    function automatic int popcount4(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    // Drive a request vector at the falling edge, then sample just after the rising edge.
    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req_v = r;
        @(posedge clk);
        #1;
        model_edge(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_v = 4'b0000;
        rst   = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req_v = 4'b0000;
        model_reset();
        #1;
        n_cmp++;
        if (gnt_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: gnt=%b expected 0000", gnt_obs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(4'b0000);
            n_cmp++;
            if (gnt_obs !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: gnt=%b expected 0000", c, gnt_obs);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_pulse();
        do_reset();
        step(4'b0001);
        n_cmp++;
        if (gnt_obs !== 4'b0001 || gnt_obs !== m_gnt) begin
            n_err++;
            $display("FAIL pulse_grant: gnt=%b expected 0001", gnt_obs);
        end
        step(4'b0000);
        n_cmp++;
        if (gnt_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL pulse_release: gnt=%b expected 0000", gnt_obs);
        end
        $display("test_single_pulse done");
    endtask

    task automatic test_two_held();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0001;
        exp_seq[3] = 4'b0010;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(4'b0011);
            n_cmp++;
            if (gnt_obs !== m_gnt) begin
                n_err++;
                $display("FAIL two_held cyc%0d: gnt=%b expected %b", c, gnt_obs, m_gnt);
            end
`ifndef ARB_LOCK_EN
            n_cmp++;
            if (gnt_obs !== exp_seq[c]) begin
                n_err++;
                $display("FAIL two_held_seq cyc%0d: gnt=%b expected %b", c, gnt_obs, exp_seq[c]);
            end
`endif
        end
`ifdef ARB_LOCK_EN
        step(4'b0010);
        n_cmp++;
        if (gnt_obs !== 4'b0010) begin
            n_err++;
            $display("FAIL lock_release: gnt=%b expected 0010", gnt_obs);
        end
`endif
        $display("test_two_held done");
    endtask

    task automatic test_all_four();
        logic [3:0] exp_g;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(4'b1111);
            n_cmp++;
            if (gnt_obs !== m_gnt || popcount4(gnt_obs) != 1) begin
                n_err++;
                $display("FAIL all_four cyc%0d: gnt=%b expected %b", c, gnt_obs, m_gnt);
            end
`ifndef ARB_LOCK_EN
            exp_g = 4'(1 << (c % 4));
            n_cmp++;
            if (gnt_obs !== exp_g) begin
                n_err++;
                $display("FAIL all_four_seq cyc%0d: gnt=%b expected %b", c, gnt_obs, exp_g);
            end
`endif
        end
        $display("test_all_four done");
    endtask

    task automatic test_withdraw();
        do_reset();
        step(4'b0100);
        n_cmp++;
        if (gnt_obs !== 4'b0100) begin
            n_err++;
            $display("FAIL withdraw_setup: gnt=%b expected 0100", gnt_obs);
        end
        step(4'b1001);
        n_cmp++;
        if (gnt_obs !== 4'b1000 || gnt_obs !== m_gnt) begin
            n_err++;
            $display("FAIL withdraw_next: gnt=%b expected 1000", gnt_obs);
        end
        step(4'b1001);
        n_cmp++;
        if (gnt_obs !== m_gnt) begin
            n_err++;
            $display("FAIL withdraw_after: gnt=%b expected %b", gnt_obs, m_gnt);
        end
`ifndef ARB_LOCK_EN
        n_cmp++;
        if (gnt_obs !== 4'b0001) begin
            n_err++;
            $display("FAIL withdraw_wrap: gnt=%b expected 0001", gnt_obs);
        end
`endif
        $display("test_withdraw done");
    endtask

    task automatic test_sequence();
        logic [3:0] seq [6];
        seq[0] = 4'b0001;
        seq[1] = 4'b0011;
        seq[2] = 4'b0101;
        seq[3] = 4'b1001;
        seq[4] = 4'b0001;
        seq[5] = 4'b0000;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            step(seq[s]);
            n_cmp++;
            if (gnt_obs !== m_gnt || popcount4(gnt_obs) > 1) begin
                n_err++;
                $display("FAIL sequence step%0d: gnt=%b expected %b", s, gnt_obs, m_gnt);
            end
        end
        n_cmp++;
        if (gnt_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL sequence_end: gnt=%b expected 0000", gnt_obs);
        end
        $display("test_sequence done");
    endtask

    task automatic test_async_reset();
        do_reset();
        step(4'b1111);
        n_cmp++;
        if (gnt_obs !== m_gnt || gnt_obs === 4'b0000) begin
            n_err++;
            $display("FAIL async_setup: gnt=%b expected %b", gnt_obs, m_gnt);
        end
        // Assert reset between edges and check it acts before the next edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (gnt_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL async_clear: gnt=%b expected 0000", gnt_obs);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(4'b1110);
        step(4'b0011);
        n_cmp++;
        if (gnt_obs !== m_gnt) begin
            n_err++;
            $display("FAIL async_resume: gnt=%b expected %b", gnt_obs, m_gnt);
        end
        do_reset();
        step(4'b1011);
        n_cmp++;
        if (gnt_obs !== 4'b0001) begin
            n_err++;
            $display("FAIL async_prio0: gnt=%b expected 0001", gnt_obs);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic [3:0] r;
        int         bad;
        bad = 0;
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 15));
            step(r);
            n_cmp++;
            if (gnt_obs !== m_gnt || popcount4(gnt_obs) > 1) begin
                n_err++;
                bad++;
                $display("FAIL random cyc%0d req=%b: gnt=%b expected %b", c, r, gnt_obs, m_gnt);
            end
        end
        $display("test_random done, %0d bad", bad);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pulse();
        test_two_held();
        test_all_four();
        test_withdraw();
        test_sequence();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rr_arbiter
